// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronised, debounced pushbutton with press/release/long-press events
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   key_in       raw asynchronous button pin (polarity set by ACTIVE_LOW)
//   key_level    debounced level, 1 = pressed
//   key_press    one-cycle pulse on an accepted press
//   key_release  one-cycle pulse on an accepted release
//   key_long     one-cycle pulse, once per press, LONG_CYCLES after the press is accepted
//   press_cnt    accepted-press count, wraps 7 -> 0
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_level,
  output logic       key_press,
  output logic       key_release,
  output logic       key_long,
  output logic [2:0] press_cnt
);

  localparam int DBC_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DBC_W-1:0]  DBC_LAST  = DBC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    PRESS_FILTER   = 2'd1,
    HELD           = 2'd2,
    RELEASE_FILTER = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic [DBC_W-1:0]  r_dbc_cnt;
  logic [LONG_W-1:0] r_long_cnt;
  logic              r_long_done;

  logic w_s;
  logic w_dbc_done;
  logic w_long_hit;
  logic w_rel_accept;

  // Normalised sample: 1 means pressed regardless of button polarity.
  assign w_s          = r_sync2 ^ ACTIVE_LOW;
  assign w_dbc_done   = (r_dbc_cnt == DBC_LAST);
  assign w_long_hit   = !r_long_done && (r_long_cnt == LONG_LAST);
  assign w_rel_accept = (r_state == RELEASE_FILTER) && !w_s && w_dbc_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= ACTIVE_LOW;
      r_sync2     <= ACTIVE_LOW;
      r_state     <= IDLE;
      r_dbc_cnt   <= '0;
      r_long_cnt  <= '0;
      r_long_done <= 1'b0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      press_cnt   <= 3'd0;
    end else begin
      r_sync1     <= key_in;
      r_sync2     <= r_sync1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;

      // Long-press timer runs through HELD and RELEASE_FILTER so a release
      // glitch does not restart it. It is skipped on the edge that accepts a
      // release, which keeps key_long and key_release from ever coinciding.
      if ((r_state == HELD || r_state == RELEASE_FILTER) && !w_rel_accept) begin
        if (w_long_hit) begin
          key_long    <= 1'b1;
          r_long_done <= 1'b1;
        end else if (!r_long_done) begin
          r_long_cnt <= r_long_cnt + 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_s) begin
            r_state   <= PRESS_FILTER;
            r_dbc_cnt <= '0;
          end
        end
        PRESS_FILTER: begin
          if (!w_s) begin
            r_state <= IDLE;
          end else if (w_dbc_done) begin
            r_state     <= HELD;
            key_level   <= 1'b1;
            key_press   <= 1'b1;
            press_cnt   <= press_cnt + 3'd1;
            r_long_cnt  <= '0;
            r_long_done <= 1'b0;
          end else begin
            r_dbc_cnt <= r_dbc_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!w_s) begin
            r_state   <= RELEASE_FILTER;
            r_dbc_cnt <= '0;
          end
        end
        RELEASE_FILTER: begin
          if (w_s) begin
            r_state <= HELD;
          end else if (w_dbc_done) begin
            r_state     <= IDLE;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            r_dbc_cnt <= r_dbc_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          key_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce
module tb_key_debounce;

  localparam int DBC = 4;
  localparam int LNG = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       key_level;
  logic       key_press;
  logic       key_release;
  logic       key_long;
  logic [2:0] press_cnt;

  int total = 0;
  int bad   = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(DBC),
    .LONG_CYCLES(LNG),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    key_in = 1'b1;
    tick(3);
    total++; if (key_level !== 1'b0) begin bad++; $display("FAIL reset_level: got %0b want 0", key_level); end
    total++; if (key_press !== 1'b0) begin bad++; $display("FAIL reset_press: got %0b want 0", key_press); end
    total++; if (key_release !== 1'b0) begin bad++; $display("FAIL reset_release: got %0b want 0", key_release); end
    total++; if (key_long !== 1'b0) begin bad++; $display("FAIL reset_long: got %0b want 0", key_long); end
    total++; if (press_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", press_cnt); end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_bounce;
    logic [0:19] pat;
    int presses;
    pat = 20'b0001100011_1111111111;
    presses = 0;
    for (int i = 0; i < 20; i++) begin
      key_in = pat[i];
      tick(1);
      if (key_press === 1'b1) presses++;
      total++;
      if (key_level !== 1'b0) begin bad++; $display("FAIL bounce_level[%0d]: got %0b want 0", i, key_level); end
    end
    total++; if (presses != 0) begin bad++; $display("FAIL bounce_press: got %0d pulses want 0", presses); end
    total++; if (press_cnt !== 3'd0) begin bad++; $display("FAIL bounce_cnt: got %0d want 0", press_cnt); end
  endtask

  task automatic test_clean_press;
    key_in = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      total++;
      if (key_press !== (i == 7)) begin bad++; $display("FAIL clean_press_t%0d: got %0b want %0b", i, key_press, (i == 7)); end
      total++;
      if (key_level !== (i == 7)) begin bad++; $display("FAIL clean_level_t%0d: got %0b want %0b", i, key_level, (i == 7)); end
    end
    total++; if (press_cnt !== 3'd1) begin bad++; $display("FAIL clean_cnt: got %0d want 1", press_cnt); end
    tick(1);
    total++; if (key_press !== 1'b0) begin bad++; $display("FAIL clean_press_width: got %0b want 0", key_press); end
    key_in = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      total++;
      if (key_release !== (i == 7)) begin bad++; $display("FAIL clean_release_t%0d: got %0b want %0b", i, key_release, (i == 7)); end
      total++;
      if (key_level !== (i != 7)) begin bad++; $display("FAIL clean_rel_level_t%0d: got %0b want %0b", i, key_level, (i != 7)); end
    end
    tick(1);
    total++; if (key_release !== 1'b0) begin bad++; $display("FAIL clean_release_width: got %0b want 0", key_release); end
  endtask

  task automatic test_release_glitch;
    int rels;
    rels = 0;
    key_in = 1'b0;
    tick(7);
    total++; if (key_press !== 1'b1) begin bad++; $display("FAIL glitch_press: got %0b want 1", key_press); end
    total++; if (press_cnt !== 3'd2) begin bad++; $display("FAIL glitch_cnt: got %0d want 2", press_cnt); end
    for (int i = 1; i <= 25; i++) begin
      if (i == 3) key_in = 1'b1;
      if (i == 5) key_in = 1'b0;
      tick(1);
      if (key_release === 1'b1) rels++;
      total++;
      if (key_long !== (i == LNG)) begin bad++; $display("FAIL glitch_long_t%0d: got %0b want %0b", i, key_long, (i == LNG)); end
      total++;
      if (key_level !== 1'b1) begin bad++; $display("FAIL glitch_level_t%0d: got %0b want 1", i, key_level); end
    end
    total++; if (rels != 0) begin bad++; $display("FAIL glitch_release: got %0d pulses want 0", rels); end
    key_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      total++;
      if (key_release !== (i == 7)) begin bad++; $display("FAIL glitch_rel_t%0d: got %0b want %0b", i, key_release, (i == 7)); end
      total++;
      if (key_long !== 1'b0) begin bad++; $display("FAIL glitch_long_after_t%0d: got %0b want 0", i, key_long); end
    end
  endtask

  task automatic test_long_hold;
    int longs;
    int rels;
    longs = 0;
    rels = 0;
    key_in = 1'b0;
    tick(7);
    total++; if (key_press !== 1'b1) begin bad++; $display("FAIL long_press: got %0b want 1", key_press); end
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (key_long === 1'b1) longs++;
      if (key_release === 1'b1) rels++;
    end
    total++; if (longs != 1) begin bad++; $display("FAIL long_pulses: got %0d want 1", longs); end
    total++; if (rels != 0) begin bad++; $display("FAIL long_early_release: got %0d want 0", rels); end
    key_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (key_release === 1'b1) rels++;
      if (key_long === 1'b1) longs++;
      if (i == 7) begin
        total++;
        if (key_release !== 1'b1) begin bad++; $display("FAIL long_release_t7: got %0b want 1", key_release); end
      end
    end
    total++; if (rels != 1) begin bad++; $display("FAIL long_release_count: got %0d want 1", rels); end
    total++; if (longs != 1) begin bad++; $display("FAIL long_total: got %0d want 1", longs); end
    total++; if (key_level !== 1'b0) begin bad++; $display("FAIL long_level_end: got %0b want 0", key_level); end
  endtask

  task automatic test_wrap;
    int presses;
    logic [2:0] exp_cnt;
    presses = 0;
    rst = 1'b1;
    key_in = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    for (int p = 1; p <= 8; p++) begin
      key_in = 1'b0;
      for (int i = 0; i < 7; i++) begin
        tick(1);
        if (key_press === 1'b1) presses++;
      end
      exp_cnt = 3'(p);
      total++;
      if (press_cnt !== exp_cnt) begin bad++; $display("FAIL wrap_cnt_p%0d: got %0d want %0d", p, press_cnt, exp_cnt); end
      key_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tick(1);
        if (key_press === 1'b1) presses++;
      end
    end
    total++; if (presses != 8) begin bad++; $display("FAIL wrap_presses: got %0d want 8", presses); end
  endtask

  task automatic test_reset_mid;
    key_in = 1'b0;
    tick(7);
    total++; if (press_cnt !== 3'd1) begin bad++; $display("FAIL mid_cnt_before: got %0d want 1", press_cnt); end
    tick(3);
    total++; if (key_level !== 1'b1) begin bad++; $display("FAIL mid_held_level: got %0b want 1", key_level); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total++; if (key_level !== 1'b0) begin bad++; $display("FAIL mid_level: got %0b want 0", key_level); end
    total++; if (key_press !== 1'b0) begin bad++; $display("FAIL mid_press: got %0b want 0", key_press); end
    total++; if (key_release !== 1'b0) begin bad++; $display("FAIL mid_release: got %0b want 0", key_release); end
    total++; if (key_long !== 1'b0) begin bad++; $display("FAIL mid_long: got %0b want 0", key_long); end
    total++; if (press_cnt !== 3'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", press_cnt); end
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      total++;
      if (key_press !== (i == 7)) begin bad++; $display("FAIL mid_repress_t%0d: got %0b want %0b", i, key_press, (i == 7)); end
    end
    total++; if (press_cnt !== 3'd1) begin bad++; $display("FAIL mid_cnt_after: got %0d want 1", press_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    key_in = 1'b1;
    test_reset;
    test_bounce;
    test_clean_press;
    test_release_glitch;
    test_long_hold;
    test_wrap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
Pushbutton front end that produces the clean `key` level and event pulses consumed by the LED state-machine blocks. It synchronises a raw, bouncing, asynchronous button input and debounces it with a 4-state FSM. It emits one-cycle press, release and long-press pulses, plus a 3-bit wrapping press counter sized to drive a 3-bit LED bank directly.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must stay stable to accept an edge (20 ms at 50 MHz); must be >= 2
LONG_CYCLES, 50000000, cycles held (counted from entry to HELD) before key_long fires; must be > DEBOUNCE_CYCLES
ACTIVE_LOW, 1, 1 = button pulls key_in low when pressed; 0 = active-high button

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
key_in  input  1  raw asynchronous button pin
key_level  output  1  debounced level, 1 = pressed
key_press  output  1  one-cycle pulse on accepted press
key_release  output  1  one-cycle pulse on accepted release
key_long  output  1  one-cycle pulse, once per press, after LONG_CYCLES held
press_cnt  output  3  count of accepted presses, wraps 7->0

Behaviour:
- Interface (decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Synchroniser: 2 flops on key_in; reset value = released level (ACTIVE_LOW ? 1 : 0).
- Normalised sample: s = sync2 XOR ACTIVE_LOW, so s = 1 means pressed.
- Reset (rst=1 at an edge): state=IDLE, dbc_cnt=0, long_cnt=0, long_done=0; all outputs 0, press_cnt=0.
- Counters: dbc_cnt width $clog2(DEBOUNCE_CYCLES); long_cnt width $clog2(LONG_CYCLES).
- FSM states: IDLE, PRESS_FILTER, HELD, RELEASE_FILTER.
- IDLE: if s=1, go to PRESS_FILTER with dbc_cnt=0.
- PRESS_FILTER:
  - if s=0, return to IDLE (bounce rejected, no pulse);
  - else if dbc_cnt==DEBOUNCE_CYCLES-1, go to HELD: key_level=1, key_press=1 for one cycle, press_cnt+=1 (mod 8), long_cnt=0, long_done=0;
  - else dbc_cnt+=1.
- HELD:
  - if s=0, go to RELEASE_FILTER with dbc_cnt=0;
  - long_cnt increments while !long_done;
  - when long_cnt==LONG_CYCLES-1 and !long_done: key_long=1 for one cycle and long_done=1, so key_long fires exactly once per press.
- RELEASE_FILTER:
  - long_cnt keeps counting as in HELD; a release glitch does not restart it;
  - if s=1, go back to HELD (no pulse; key_level stays 1);
  - else if dbc_cnt==DEBOUNCE_CYCLES-1, go to IDLE: key_level=0, key_release=1 for one cycle;
  - else dbc_cnt+=1.
- key_long may fire while in RELEASE_FILTER if long_cnt reaches the threshold there.
- All outputs are registered. key_press and press_cnt update on the same edge.
- key_press, key_release and key_long are mutually exclusive by construction; they are never high together.
- Latency: raw change captured into sync1 at edge E0, stable thereafter.
  - key_press is high in the cycle after edge E0+DEBOUNCE_CYCLES+2.
  - key_release follows the same timing from the release edge.
- Reset mid-press: the FSM restarts in IDLE. A button still held after reset deasserts is debounced again and yields a fresh key_press.
- press_cnt wrap: the 8th press takes it 7->0 with no flag.
- Default state encoding: any illegal state goes to IDLE on the next edge.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1, unless stated.
- Clean press: key_in 1->0 captured at edge E0 and held -> key_press high exactly in the cycle after E0+6; key_level=1 from then; press_cnt=1.
- Bounce rejection: key_in low for 3 cycles, high 2, low 3, high (never 4 stable) -> no key_press; key_level stays 0; press_cnt=0.
- Release glitch:
  - stimulus: while HELD, key_in high for 2 cycles then low again;
  - response: no key_release; key_level stays 1; long_cnt continues; key_long fires once, 20 cycles after HELD entry.
- Long hold: hold 100 cycles, then release cleanly -> exactly one key_long pulse and exactly one key_release, in the cycle after release-capture edge +6.
- Wrap: 8 clean press/release pairs -> press_cnt goes 1,2,...,7,0 with exactly 8 key_press pulses.
- Reset mid-operation: assert rst for 1 cycle during HELD with key still low -> next cycle all outputs 0 and press_cnt=0; key_press re-fires 7 cycles after rst deasserts.
